new_cacheline_adapter: RTL and testbench

NEW_CACHELINE_ADAPTER -- requirements
Module: new_cacheline_adapter

---
 rtl/new_cacheline_adapter.sv | 147 ++++++++++++++
 tb/tb_new_cacheline_adapter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/new_cacheline_adapter.sv
// Cache line <-> memory burst adapter: splits a writeback line into beats
// and assembles fill beats into a line. Optional macro NEW_CACHELINE_ADAPTER_PERF_CNT_EN.
module new_cacheline_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
`ifdef NEW_CACHELINE_ADAPTER_PERF_CNT_EN
    ,
    output logic [31:0]        rd_count_o,
    output logic [31:0]        wr_count_o
`endif
);

    localparam int BEATS = s_line / s_burst;
    localparam int CW    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [s_line-1:0] r_line;
    logic [s_line-1:0] r_wline;
    logic [31:0]       r_addr;
    logic              w_busy;
    logic              w_last;

    assign w_busy = (r_state == READ) || (r_state == WRITE);
    assign w_last = (r_cnt == CW'(BEATS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; requests only matter in IDLE
    always_comb begin
        w_next  = r_state;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_next = WRITE;
                end else if (read_i) begin
                    w_next = READ;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && w_last) begin
                    w_next = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                if (resp_i && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                resp_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latching, beat counting and fill-line assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_line  <= '0;
            r_wline <= '0;
            r_addr  <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (write_i) begin
                    r_addr  <= address_i & ~32'h1f;
                    r_wline <= line_i;
                    r_cnt   <= '0;
                end else if (read_i) begin
                    r_addr <= address_i & ~32'h1f;
                    r_cnt  <= '0;
                end
            end
            if (w_busy && resp_i) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if ((r_state == READ) && resp_i) begin
                r_line[s_burst*r_cnt +: s_burst] <= burst_i;
            end
        end
    end

    assign line_o    = r_line;
    assign address_o = r_addr;
    assign burst_o   = r_wline[s_burst*r_cnt +: s_burst];

`ifdef NEW_CACHELINE_ADAPTER_PERF_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    // Completed-transfer counters, bumped as the FSM enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (resp_i && w_last) begin
            if (r_state == READ) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (r_state == WRITE) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign rd_count_o = r_rd_cnt;
    assign wr_count_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_new_cacheline_adapter.sv
// Scoreboard bench for new_cacheline_adapter: stimulus queues expected
// transfers and write beats, a negedge monitor pops and compares them.
module tb_new_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;
`ifdef NEW_CACHELINE_ADAPTER_PERF_CNT_EN
    logic [31:0]  rd_count_o;
    logic [31:0]  wr_count_o;
`endif

    new_cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
`ifdef NEW_CACHELINE_ADAPTER_PERF_CNT_EN
        ,
        .rd_count_o(rd_count_o),
        .wr_count_o(wr_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [255:0] line;
        logic [31:0]  addr;
        int           cyc;
    } txn_t;

    txn_t        exp_q[$];
    logic [63:0] beat_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_rd = 0;
    int          n_wr = 0;

    localparam logic [255:0] L33 = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] LW  = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
                                    64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
    localparam logic [255:0] LG  = {64'hCAFE0003CAFE0003, 64'hBEEF0002BEEF0002,
                                    64'hF00D0001F00D0001, 64'hA5A50000A5A50000};
    localparam logic [255:0] LB  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                    64'h55AA55AA55AA55AA, 64'h0F0F0F0F0F0F0F0F};
    localparam logic [255:0] LN  = {64'h9999999999999999, 64'h8888888888888888,
                                    64'h7777777777777777, 64'h6666666666666666};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT activity against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if ((read_o || write_o) && exp_q.size() > 0) begin
                chk("mode", {read_o, write_o}, exp_q[0].wr ? 2'b01 : 2'b10);
                chk("address_o", address_o, exp_q[0].addr);
            end
            if (write_o && resp_i) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    chk("burst_o", burst_o, beat_q.pop_front());
                end
            end
            if (resp_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp_o", 1'b1, 1'b0);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("resp_cycle", cyc, t.cyc);
                    if (!t.wr) chk("line_o", line_o, t.line);
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [255:0] l,
                           input int gap);
        txn_t t;
        t.wr   = 1'b0;
        t.line = l;
        t.addr = a & ~32'h1f;
        t.cyc  = cyc + 5 + 3 * gap;
        exp_q.push_back(t);
        n_rd++;
        read_i    = 1'b1;
        address_i = a;
        step();
        read_i    = 1'b0;
        address_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (gap) step();
            resp_i  = 1'b1;
            burst_i = l[64*k +: 64];
            step();
            resp_i  = 1'b0;
            burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] l,
                            input int gap, input bit both);
        txn_t t;
        t.wr   = 1'b1;
        t.line = l;
        t.addr = a & ~32'h1f;
        t.cyc  = cyc + 5 + 3 * gap;
        exp_q.push_back(t);
        n_wr++;
        write_i   = 1'b1;
        read_i    = both;
        address_i = a;
        line_i    = l;
        step();
        write_i = 1'b0;
        read_i  = 1'b0;
        line_i  = ~l;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (gap) step();
            beat_q.push_back(l[64*k +: 64]);
            resp_i = 1'b1;
            step();
            resp_i = 1'b0;
        end
        step();
    endtask

    initial begin
        repeat (2) step();
        chk("rst_line_o", line_o, 256'h0);
        chk("rst_address_o", address_o, 32'h0);
        chk("rst_burst_o", burst_o, 64'h0);
        chk("rst_strobes", {read_o, write_o, resp_o}, 3'b000);
        rst = 1'b0;
        step();

        // resp_i in IDLE must be ignored
        resp_i = 1'b1;
        repeat (3) step();
        resp_i = 1'b0;
        chk("idle_strobes", {read_o, write_o, resp_o}, 3'b000);

        // abort a read after two beats
        read_i    = 1'b1;
        address_i = 32'h0000_4040;
        step();
        read_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            resp_i  = 1'b1;
            burst_i = LB[64*k +: 64];
            step();
        end
        resp_i = 1'b0;
        rst    = 1'b1;
        #1;
        chk("abort_read_o", read_o, 1'b0);
        chk("abort_line_o", line_o, 256'h0);
        chk("abort_address_o", address_o, 32'h0);
        step();
        rst  = 1'b0;
        n_rd = 0;
        n_wr = 0;
        step();
        do_read(32'h0000_2008, LN, 0);

        do_read(32'h0000_1000, L33, 0);
        do_write(32'h0000_1234, LW, 0, 1'b0);
        chk("line_o_hold", line_o, L33);
        do_read(32'h0000_3FFF, LG, 3);
        do_write(32'hABCD_EF3F, LB, 1, 1'b1);
        repeat (3) step();

        chk("exp_q_empty", exp_q.size(), 0);
        chk("beat_q_empty", beat_q.size(), 0);
`ifdef NEW_CACHELINE_ADAPTER_PERF_CNT_EN
        chk("rd_count_o", rd_count_o, n_rd);
        chk("wr_count_o", wr_count_o, n_wr);
`endif
        rst = 1'b1;
        #1;
        chk("final_rst_line_o", line_o, 256'h0);
        chk("final_rst_burst_o", burst_o, 64'h0);
`ifdef NEW_CACHELINE_ADAPTER_PERF_CNT_EN
        chk("rst_rd_count_o", rd_count_o, 32'h0);
        chk("rst_wr_count_o", wr_count_o, 32'h0);
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
